// File: rtl/counter_sched.sv
// Arbitrated scheduler that drives a shared external up/down counter.
// Define COUNTER_SCHED_FIXED_PRIO_EN for fixed priority; default is round-robin.
module counter_sched #(
  parameter int unsigned BIT_WIDTH = 4,
  parameter int unsigned NREQ      = 4
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [NREQ-1:0]           i_req,
  input  logic [NREQ*BIT_WIDTH-1:0] i_req_load,
  input  logic [NREQ-1:0]           i_req_dir,
  input  logic [NREQ*BIT_WIDTH-1:0] i_req_steps,
  output logic [NREQ-1:0]           o_gnt,
  output logic [NREQ-1:0]           o_done,
  output logic [BIT_WIDTH-1:0]      o_result,
  output logic                      o_busy,
  output logic                      o_cnt_reset,
  output logic                      o_cnt_load_en,
  output logic [BIT_WIDTH-1:0]      o_cnt_load,
  output logic                      o_cnt_chnge,
  input  logic [BIT_WIDTH-1:0]      i_cnt_out
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IDX_W-1:0]     r_win;
  logic [BIT_WIDTH-1:0] r_steps;
  logic [BIT_WIDTH-1:0] r_rem;

  logic                 w_found;
  logic [IDX_W-1:0]     w_win;
  logic [IDX_W-1:0]     w_cand;
  logic [BIT_WIDTH-1:0] w_sel_load;
  logic [BIT_WIDTH-1:0] w_sel_steps;
  logic                 w_sel_dir;

  logic [NREQ-1:0]      w_gnt_nxt;
  logic [NREQ-1:0]      w_done_nxt;
  logic                 w_busy_nxt;
  logic                 w_cnt_reset_nxt;
  logic                 w_load_en_nxt;
  logic [BIT_WIDTH-1:0] w_cnt_load_nxt;
  logic                 w_chnge_nxt;

`ifdef COUNTER_SCHED_FIXED_PRIO_EN
  // Fixed priority: lowest requesting index wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_cand = IDX_W'(k);
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end
`else
  logic [IDX_W-1:0] r_ptr;

  // Round-robin: search starts one past the last completed owner.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_cand = IDX_W'((32'(r_ptr) + k) % NREQ);
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end
`endif

  // Operand mux for the candidate winner.
  always_comb begin
    w_sel_load  = '0;
    w_sel_steps = '0;
    w_sel_dir   = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (w_win == IDX_W'(k)) begin
        w_sel_load  = i_req_load[k*BIT_WIDTH +: BIT_WIDTH];
        w_sel_steps = i_req_steps[k*BIT_WIDTH +: BIT_WIDTH];
        w_sel_dir   = i_req_dir[k];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_found) w_state_nxt = S_LOAD;
      S_LOAD: w_state_nxt = (r_steps != '0) ? S_RUN : S_DONE;
      S_RUN:  if (r_rem == BIT_WIDTH'(1)) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output values for the state about to be entered; registered below.
  always_comb begin
    w_gnt_nxt       = '0;
    w_done_nxt      = '0;
    w_busy_nxt      = 1'b0;
    w_cnt_reset_nxt = 1'b1;
    w_load_en_nxt   = 1'b0;
    w_cnt_load_nxt  = o_cnt_load;
    w_chnge_nxt     = o_cnt_chnge;
    case (w_state_nxt)
      S_LOAD: begin
        w_gnt_nxt       = NREQ'(1) << w_win;
        w_busy_nxt      = 1'b1;
        w_cnt_reset_nxt = 1'b0;
        w_load_en_nxt   = 1'b1;
        w_cnt_load_nxt  = w_sel_load;
        w_chnge_nxt     = w_sel_dir;
      end
      S_RUN: begin
        w_gnt_nxt       = NREQ'(1) << r_win;
        w_busy_nxt      = 1'b1;
        w_cnt_reset_nxt = 1'b0;
      end
      S_DONE: begin
        w_gnt_nxt       = NREQ'(1) << r_win;
        w_done_nxt      = NREQ'(1) << r_win;
        w_busy_nxt      = 1'b1;
        w_cnt_reset_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_gnt         <= '0;
      o_done        <= '0;
      o_busy        <= 1'b0;
      o_cnt_reset   <= 1'b1;
      o_cnt_load_en <= 1'b0;
      o_cnt_load    <= '0;
      o_cnt_chnge   <= 1'b0;
    end else begin
      o_gnt         <= w_gnt_nxt;
      o_done        <= w_done_nxt;
      o_busy        <= w_busy_nxt;
      o_cnt_reset   <= w_cnt_reset_nxt;
      o_cnt_load_en <= w_load_en_nxt;
      o_cnt_load    <= w_cnt_load_nxt;
      o_cnt_chnge   <= w_chnge_nxt;
    end
  end

  // Owner capture, remaining-step count and result sampling.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_win    <= '0;
      r_steps  <= '0;
      r_rem    <= '0;
      o_result <= '0;
`ifndef COUNTER_SCHED_FIXED_PRIO_EN
      r_ptr    <= IDX_W'(NREQ - 1);
`endif
    end else begin
      if (r_state == S_IDLE && w_found) begin
        r_win   <= w_win;
        r_steps <= w_sel_steps;
      end
      if (r_state == S_LOAD)     r_rem <= r_steps;
      else if (r_state == S_RUN) r_rem <= r_rem - BIT_WIDTH'(1);
      if (r_state == S_DONE) begin
        o_result <= i_cnt_out;
`ifndef COUNTER_SCHED_FIXED_PRIO_EN
        r_ptr    <= r_win;
`endif
      end
    end
  end

endmodule
